bcd_sum_display: RTL and testbench

- Consumes the 8-bit packed-BCD sum and carry-out from the two-digit BCD adder stage.
- Latches the result on a valid strobe and time-multiplexes it onto a 4-digit common-anode 7-segment display as a 3-digit decimal value, 000–199.
- The carry drives the hundreds digit. Optional leading-zero blanking; any non-BCD nibble shows as 'E'.
- Sits directly after the adder, at the board display pins.

---
 rtl/bcd_sum_display_if.sv | 22 ++
 rtl/bcd_sum_display.sv | 153 +++++++++++++++
 tb/tb_bcd_sum_display.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_sum_display_if.sv
// Display-side bundle between the BCD adder stage and the 7-segment driver.
// The master produces the adder result and blanking control; the slave
// (the display driver) returns the registered segment, anode and dp pins.
interface bcd_sum_display_if;
    logic       sum_valid;  // one-cycle capture strobe
    logic [7:0] sum;        // packed BCD: [7:4] tens, [3:0] ones
    logic       sum_cout;   // hundreds digit (0 or 1)
    logic       blank_lz;   // 1 = blank leading zeros, sampled live
    logic [6:0] seg;        // {g,f,e,d,c,b,a}, active-low
    logic [3:0] an;         // digit anodes, active-low
    logic       dp;         // decimal point, active-low (always off)

    modport master (
        output sum_valid, sum, sum_cout, blank_lz,
        input  seg, an, dp
    );

    modport slave (
        input  sum_valid, sum, sum_cout, blank_lz,
        output seg, an, dp
    );
endinterface

// File: rtl/bcd_sum_display.sv
// Latches the adder's packed-BCD sum and carry, then scans them onto three
// digits of a common-anode 7-segment display as 000..199. Digits are selected
// round-robin (ones, tens, hundreds) every REFRESH_DIV cycles. Segment and
// anode outputs are registered, so they trail the scan index and the held
// value by exactly one clock.
module bcd_sum_display #(
    parameter int unsigned REFRESH_DIV = 100000  // cycles per digit, 1..2^20
) (
    input  logic             clk,
    input  logic             rst,
    bcd_sum_display_if.slave bus
);

    // A one-cycle refresh still needs a 1-bit counter that simply stays at 0.
    localparam int unsigned      CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_E   = 7'b0000110;

    // Scan position. Encoding matches the anode bit driven for each digit;
    // the fourth anode is never selected.
    typedef enum logic [1:0] {
        DIG_ONES  = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUNDS = 2'd2
    } digit_sel_t;

    // Active-low 7-segment pattern {g,f,e,d,c,b,a}; any non-BCD code shows 'E'.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

    // Held adder result
    logic [7:0]       hold_sum_q;
    logic             hold_c_q;

    // Refresh divider and scan state
    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;
    logic             tick;
    digit_sel_t       idx_q;
    digit_sel_t       idx_d;

    // Digit selection and output registers
    logic [3:0]       digit_val;
    logic             digit_blank;
    logic [6:0]       seg_d;
    logic [6:0]       seg_q;
    logic [3:0]       an_d;
    logic [3:0]       an_q;

    // Capture the adder result on every strobe; the newest strobe always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_sum_q <= 8'h00;
            hold_c_q   <= 1'b0;
        end else if (bus.sum_valid) begin
            hold_sum_q <= bus.sum;
            hold_c_q   <= bus.sum_cout;
        end
    end

    assign tick = (div_cnt_q == CNT_LAST);

    // Free-running refresh divider; captures never disturb it.
    always_comb begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
        if (tick) begin
            div_cnt_d = '0;
        end
    end

    // Next scan position: ones -> tens -> hundreds -> ones, once per tick.
    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            case (idx_q)
                DIG_ONES: idx_d = DIG_TENS;
                DIG_TENS: idx_d = DIG_HUNDS;
                default:  idx_d = DIG_ONES;
            endcase
        end
    end

    // Divider and scan-state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            idx_q     <= DIG_ONES;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
        end
    end

    // Pick the digit under the scan and decide whether it is a leading zero.
    // Tens is only a leading zero when it really is 0 (an 'E' nibble is never
    // hidden) and there is no hundreds digit in front of it.
    always_comb begin
        digit_val   = 4'h0;
        digit_blank = 1'b0;
        case (idx_q)
            DIG_ONES: begin
                digit_val = hold_sum_q[3:0];
            end
            DIG_TENS: begin
                digit_val   = hold_sum_q[7:4];
                digit_blank = bus.blank_lz && !hold_c_q && (hold_sum_q[7:4] == 4'h0);
            end
            default: begin
                digit_val   = {3'b000, hold_c_q};
                digit_blank = bus.blank_lz && !hold_c_q;
            end
        endcase
    end

    // Next segment/anode pattern for the currently selected digit.
    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = digit_blank ? SEG_OFF : seg_decode(digit_val);
    end

    // Registered display pins; all segments and anodes off while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            an_q  <= 4'b1111;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_bcd_sum_display.sv
// Directed bench for bcd_sum_display with REFRESH_DIV = 4: reset scan pattern,
// capture latency, mid-scan strobe and reset, plus a table of sum/carry/blanking
// vectors checked on a chosen digit.
module tb_bcd_sum_display;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    bcd_sum_display_if bus ();

    bcd_sum_display #(.REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       blz;
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] scan_pat[3] = '{4'b1110, 4'b1101, 4'b1011};

    task automatic check_seg(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: seg got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check_an(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: an got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check_dp(input string name, input logic act);
        tests++;
        if (act !== 1'b1) begin
            fails++;
            $display("FAIL %s: dp got %b, want 1", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance at least one edge, then until an == target. With need_entry the
    // target must be freshly selected (first cycle of that digit).
    task automatic wait_an(input logic [3:0] target, input logic need_entry);
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        prev  = bus.an;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (bus.an == target && (!need_entry || prev != target)) found = 1'b1;
            prev = bus.an;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL wait_an: an got %b, want %b", bus.an, target);
        end
    endtask

    // Called #1 after an edge; the capture happens on the following edge.
    task automatic strobe(input logic [7:0] s, input logic c, input logic blz);
        bus.sum       = s;
        bus.sum_cout  = c;
        bus.blank_lz  = blz;
        bus.sum_valid = 1'b1;
        step();
        bus.sum_valid = 1'b0;
    endtask

    initial begin
        bus.sum_valid = 1'b0;
        bus.sum       = 8'h00;
        bus.sum_cout  = 1'b0;
        bus.blank_lz  = 1'b0;
        rst           = 1'b1;

        // sum, cout, blank_lz, digit anode, expected segments
        vecs.push_back(vec_t'{8'h47, 1'b0, 1'b1, 4'b1110, 7'b1111000});
        vecs.push_back(vec_t'{8'h47, 1'b0, 1'b1, 4'b1101, 7'b0011001});
        vecs.push_back(vec_t'{8'h47, 1'b0, 1'b1, 4'b1011, 7'b1111111});
        vecs.push_back(vec_t'{8'h05, 1'b0, 1'b1, 4'b1110, 7'b0010010});
        vecs.push_back(vec_t'{8'h05, 1'b0, 1'b1, 4'b1101, 7'b1111111});
        vecs.push_back(vec_t'{8'h05, 1'b0, 1'b1, 4'b1011, 7'b1111111});
        vecs.push_back(vec_t'{8'h05, 1'b0, 1'b0, 4'b1101, 7'b1000000});
        vecs.push_back(vec_t'{8'h05, 1'b0, 1'b0, 4'b1011, 7'b1000000});
        vecs.push_back(vec_t'{8'h00, 1'b1, 1'b1, 4'b1011, 7'b1111001});
        vecs.push_back(vec_t'{8'h00, 1'b1, 1'b1, 4'b1101, 7'b1000000});
        vecs.push_back(vec_t'{8'h00, 1'b1, 1'b1, 4'b1110, 7'b1000000});
        vecs.push_back(vec_t'{8'h3C, 1'b0, 1'b1, 4'b1110, 7'b0000110});
        vecs.push_back(vec_t'{8'h3C, 1'b0, 1'b1, 4'b1101, 7'b0110000});
        vecs.push_back(vec_t'{8'h3C, 1'b0, 1'b1, 4'b1011, 7'b1111111});
        vecs.push_back(vec_t'{8'hA2, 1'b0, 1'b1, 4'b1101, 7'b0000110});
        vecs.push_back(vec_t'{8'hA2, 1'b0, 1'b1, 4'b1110, 7'b0100100});
        vecs.push_back(vec_t'{8'hA2, 1'b0, 1'b1, 4'b1011, 7'b1111111});
        vecs.push_back(vec_t'{8'h99, 1'b1, 1'b1, 4'b1011, 7'b1111001});
        vecs.push_back(vec_t'{8'h99, 1'b1, 1'b1, 4'b1101, 7'b0010000});
        vecs.push_back(vec_t'{8'h99, 1'b1, 1'b1, 4'b1110, 7'b0010000});
        vecs.push_back(vec_t'{8'h68, 1'b0, 1'b0, 4'b1011, 7'b1000000});
        vecs.push_back(vec_t'{8'h68, 1'b0, 1'b0, 4'b1101, 7'b0000010});
        vecs.push_back(vec_t'{8'h68, 1'b0, 1'b0, 4'b1110, 7'b0000000});
        vecs.push_back(vec_t'{8'h0F, 1'b1, 1'b1, 4'b1101, 7'b1000000});
        vecs.push_back(vec_t'{8'h0F, 1'b1, 1'b1, 4'b1110, 7'b0000110});
        vecs.push_back(vec_t'{8'h10, 1'b0, 1'b1, 4'b1101, 7'b1111001});
        vecs.push_back(vec_t'{8'h10, 1'b0, 1'b1, 4'b1011, 7'b1111111});
        vecs.push_back(vec_t'{8'h00, 1'b0, 1'b1, 4'b1110, 7'b1000000});
        vecs.push_back(vec_t'{8'h00, 1'b0, 1'b1, 4'b1101, 7'b1111111});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_seg("reset_seg", bus.seg, 7'b1111111);
        check_an("reset_an", bus.an, 4'b1111);
        check_dp("reset_dp", bus.dp);

        // Release mid-cycle; edge 1 afterwards selects the ones digit
        @(posedge clk);
        #3 rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step();
            check_an($sformatf("scan_an_e%0d", k), bus.an, scan_pat[((k - 1) / 4) % 3]);
            check_seg($sformatf("scan_seg_e%0d", k), bus.seg, 7'b1000000);
            check_dp($sformatf("scan_dp_e%0d", k), bus.dp);
        end

        // Capture latency on the active digit
        wait_an(4'b1110, 1'b1);
        strobe(8'h47, 1'b0, 1'b1);
        check_an("lat_capture_an", bus.an, 4'b1110);
        check_seg("lat_capture_seg", bus.seg, 7'b1000000);
        step();
        check_an("lat_next_an", bus.an, 4'b1110);
        check_seg("lat_next_seg", bus.seg, 7'b1111000);

        // Strobe during the tens digit leaves the scan phase alone
        wait_an(4'b1101, 1'b1);
        strobe(8'h12, 1'b0, 1'b1);
        check_an("mid_an_c2", bus.an, 4'b1101);
        step();
        check_an("mid_an_c3", bus.an, 4'b1101);
        check_seg("mid_seg_c3", bus.seg, 7'b1111001);
        step();
        check_an("mid_an_c4", bus.an, 4'b1101);
        step();
        check_an("mid_an_next", bus.an, 4'b1011);
        check_seg("mid_seg_next", bus.seg, 7'b1111111);

        // Table vectors
        foreach (vecs[i]) begin
            strobe(vecs[i].sum, vecs[i].cout, vecs[i].blz);
            wait_an(vecs[i].an, 1'b0);
            check_seg($sformatf("vec%0d", i), bus.seg, vecs[i].seg);
        end

        // blank_lz is live: dropping it reveals the zero tens from the next edge
        strobe(8'h05, 1'b0, 1'b1);
        wait_an(4'b1101, 1'b1);
        check_seg("blz_on_tens", bus.seg, 7'b1111111);
        bus.blank_lz = 1'b0;
        step();
        check_an("blz_off_an", bus.an, 4'b1101);
        check_seg("blz_off_tens", bus.seg, 7'b1000000);

        // Asynchronous reset mid-cycle, then release
        strobe(8'h47, 1'b1, 1'b0);
        step();
        #2 rst = 1'b1;
        #1;
        check_seg("arst_seg", bus.seg, 7'b1111111);
        check_an("arst_an", bus.an, 4'b1111);
        check_dp("arst_dp", bus.dp);
        @(posedge clk);
        #1;
        check_an("arst_hold_an", bus.an, 4'b1111);
        #2 rst = 1'b0;
        step();
        check_an("rel_an", bus.an, 4'b1110);
        check_seg("rel_ones", bus.seg, 7'b1000000);
        wait_an(4'b1101, 1'b1);
        check_seg("rel_tens", bus.seg, 7'b1000000);
        wait_an(4'b1011, 1'b1);
        check_seg("rel_hunds", bus.seg, 7'b1000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
